// File: rtl/demux_pipeline_pkg.sv
// demux_pipeline_pkg
//   Shared N-ary tree helpers for the pipelined mux/demux toolbox blocks.
//   Level 0 is the root; level f_TreeLevels() is the row of leaf lanes.
//   A node at level l covers f_LevelSpan() consecutive lanes. Nodes whose
//   first lane is at or beyond the lane count are pruned.
package demux_pipeline_pkg;

  // Number of registered levels: ceil(clog2(count) / log2(size)), at least 1.
  function automatic int f_TreeLevels(input int count, input int size);
    int b;
    int c;
    int lv;
    b  = $clog2(size);
    c  = $clog2(count);
    lv = (c + b - 1) / b;
    if (lv < 1) lv = 1;
    return lv;
  endfunction

  // Lanes addressed by one node at the given level (size ** (levels - level)).
  function automatic int f_LevelSpan(input int count, input int size, input int level);
    int span;
    span = 1;
    for (int i = 0; i < f_TreeLevels(count, size) - level; i++) span = span * size;
    return span;
  endfunction

  // Existing (unpruned) nodes at a level; level == levels gives the lane count.
  function automatic int f_NodeCount(input int count, input int size, input int level);
    int span;
    span = f_LevelSpan(count, size, level);
    return (count + span - 1) / span;
  endfunction

  // Real lanes covered by a node after clipping against the lane count.
  function automatic int f_NodeSpan(input int count, input int size, input int level,
                                    input int node);
    int span;
    int left;
    span = f_LevelSpan(count, size, level);
    left = count - node * span;
    return (left < span) ? left : span;
  endfunction

  // Children that survive pruning below a node.
  function automatic int f_ChildCount(input int count, input int size, input int level,
                                      input int node);
    int cspan;
    cspan = f_LevelSpan(count, size, level) / size;
    return (f_NodeSpan(count, size, level, node) + cspan - 1) / cspan;
  endfunction

endpackage

// File: rtl/demux_pipeline_node.sv
// demux_pipeline_node
//   One registered 1-to-CHILDREN tree node. The top SLICE_W bits of sel_in
//   pick the child; the remaining low sel bits travel on with the word.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     vld_in/sel_in/data_in   word arriving from the parent
//     child_vld/child_sel/child_data   per-child registered word
//   A slice value >= CHILDREN matches no child, so the word is dropped.
module demux_pipeline_node #(
  parameter int WIDTH    = 4,
  parameter int SEL_W    = 1,
  parameter int SLICE_W  = 1,
  parameter int CHILDREN = 2,
  localparam int CSEL_W  = (SEL_W > SLICE_W) ? SEL_W - SLICE_W : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             vld_in,
  input  logic [SEL_W-1:0]                 sel_in,
  input  logic [WIDTH-1:0]                 data_in,
  output logic [CHILDREN-1:0]              child_vld,
  output logic [CHILDREN-1:0][CSEL_W-1:0]  child_sel,
  output logic [CHILDREN-1:0][WIDTH-1:0]   child_data
);

  logic [SLICE_W-1:0] slice;
  logic [CSEL_W-1:0]  rest;

  assign slice = sel_in[SEL_W-1 -: SLICE_W];

  // A leaf node has no lower sel bits left to forward.
  if (SEL_W > SLICE_W) begin : g_rest
    assign rest = sel_in[SEL_W-SLICE_W-1:0];
  end else begin : g_norest
    assign rest = '0;
  end

  // Stage boundary: parent word -> selected child register.
  always_ff @(posedge clk) begin
    if (rst) begin
      child_vld  <= '0;
      child_sel  <= '0;
      child_data <= '0;
    end else begin
      for (int c = 0; c < CHILDREN; c++) begin
        child_vld[c] <= vld_in && (slice == SLICE_W'(c));
        if (vld_in && (slice == SLICE_W'(c))) begin
          child_sel[c]  <= rest;
          child_data[c] <= data_in;
        end
      end
    end
  end

endmodule

// File: rtl/demux_pipeline.sv
// demux_pipeline
//   Pipelined 1-to-OUTPUT_COUNT demultiplexer built as a registered tree of
//   DEMUX_SIZE-way nodes. Fixed latency of f_TreeLevels() cycles, one word
//   per cycle, no backpressure.
//   Ports:
//     clk        clock (rising edge)
//     rst        synchronous reset, active-high
//     in_valid   word present on in this cycle
//     sel        destination lane, sampled with in_valid
//     in         data word
//     out        lane data, lane k at out[k*WIDTH +: WIDTH]; holds between words
//     out_valid  one-cycle strobe per delivered word, bit k for lane k
module demux_pipeline
  import demux_pipeline_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int OUTPUT_COUNT = 2,
  parameter int DEMUX_SIZE   = 2,
  localparam int SEL_IN_W    = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [SEL_IN_W-1:0]           sel,
  input  logic [WIDTH-1:0]              in,
  output logic [WIDTH*OUTPUT_COUNT-1:0] out,
  output logic [OUTPUT_COUNT-1:0]       out_valid
);

  localparam int B  = $clog2(DEMUX_SIZE);
  localparam int L  = f_TreeLevels(OUTPUT_COUNT, DEMUX_SIZE);
  localparam int SW = L * B;

  logic [SW-1:0] sel_root;

  // With a single lane the tree is one node whose only child always matches.
  if (OUTPUT_COUNT == 1) begin : g_single
    logic unused_sel;
    assign unused_sel = ^sel;
    assign sel_root   = '0;
  end else begin : g_multi
    assign sel_root = SW'(sel);
  end

  for (genvar l = 0; l < L; l++) begin : lvl
    localparam int NN     = f_NodeCount(OUTPUT_COUNT, DEMUX_SIZE, l);
    localparam int NC     = f_NodeCount(OUTPUT_COUNT, DEMUX_SIZE, l + 1);
    localparam int SIN_W  = (L - l) * B;
    localparam int SOUT_W = (l == L - 1) ? 1 : (L - l - 1) * B;

    // Registered outputs of this level, indexed by child slot at level l+1.
    wire [NC-1:0]             vld_p;
    wire [NC-1:0][SOUT_W-1:0] sel_p;
    wire [NC-1:0][WIDTH-1:0]  data_p;

    for (genvar n = 0; n < NN; n++) begin : node
      localparam int NCH = f_ChildCount(OUTPUT_COUNT, DEMUX_SIZE, l, n);

      logic             vld_i;
      logic [SIN_W-1:0] sel_i;
      logic [WIDTH-1:0] data_i;

      if (l == 0) begin : g_root
        assign vld_i  = in_valid;
        assign sel_i  = sel_root;
        assign data_i = in;
      end else begin : g_inner
        assign vld_i  = lvl[l-1].vld_p[n];
        assign sel_i  = lvl[l-1].sel_p[n];
        assign data_i = lvl[l-1].data_p[n];
      end

      demux_pipeline_node #(
        .WIDTH    (WIDTH),
        .SEL_W    (SIN_W),
        .SLICE_W  (B),
        .CHILDREN (NCH)
      ) u_node (
        .clk        (clk),
        .rst        (rst),
        .vld_in     (vld_i),
        .sel_in     (sel_i),
        .data_in    (data_i),
        .child_vld  (vld_p[n*DEMUX_SIZE +: NCH]),
        .child_sel  (sel_p[n*DEMUX_SIZE +: NCH]),
        .child_data (data_p[n*DEMUX_SIZE +: NCH])
      );
    end

    // Leaf children carry no remaining sel bits.
    if (l == L - 1) begin : g_leaf
      logic unused_leaf_sel;
      assign unused_leaf_sel = ^sel_p;
    end
  end

  for (genvar k = 0; k < OUTPUT_COUNT; k++) begin : g_lane
    assign out[k*WIDTH +: WIDTH] = lvl[L-1].data_p[k];
  end

  assign out_valid = lvl[L-1].vld_p;

endmodule

// File: doc/demux_pipeline.md
Name: demux_pipeline

Overview:
Pipelined 1-to-N demultiplexer; the distribution-side counterpart of the toolbox's pipelined selection mux. A registered tree of DEMUX_SIZE-way nodes routes one WIDTH-bit word per cycle to one of OUTPUT_COUNT output lanes, with fixed latency. Each lane carries a valid strobe. Used to fan one high-speed stream out to multiple consumers without a wide combinational decoder on the critical path.

Parameters:
WIDTH, 4, data width per lane in bits.
OUTPUT_COUNT, 2, number of output lanes; must be at least 1.
DEMUX_SIZE, 2, fan-out per tree node; must be a power of 2 (2, 4, 8, 16, ...).

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  word present on in this cycle.
sel  input  max($clog2(OUTPUT_COUNT),1)  destination lane index, sampled with in_valid.
in  input  WIDTH  data word.
out  output  WIDTH*OUTPUT_COUNT  lane data; lane k is out[k*WIDTH +: WIDTH].
out_valid  output  OUTPUT_COUNT  per-lane strobe; bit k high for one cycle when lane k receives a word.

Behaviour:
- Definitions: B = log2(DEMUX_SIZE). L = number of levels = max(1, ceil($clog2(OUTPUT_COUNT)/B)). sel is zero-extended to L*B bits.
- Latency: exactly L cycles. A word accepted on cycle t appears on cycle t+L in out_valid[sel] and out[sel]. L does not depend on sel.
- Throughput: one word per cycle. There is no backpressure and no stall.
- Tree structure:
  - Level 0 is the root and decodes the most-significant B bits of the padded sel. Level L-1 decodes the least-significant B bits and drives the output registers.
  - Each node registers data, valid, and the remaining (lower) sel bits into its selected child only.
  - Children that do not exist, because their index range is at or beyond OUTPUT_COUNT, are pruned and not instantiated.
- Node register rules:
  - Child valid <= parent valid AND (parent sel slice == child index).
  - Child data and remaining sel load only when the child's valid is being set. Otherwise they hold.
- Output lane rules:
  - out[k] holds its last delivered value until the next word for lane k arrives.
  - out_valid[k] is a single-cycle pulse per word.
  - At most one out_valid bit is high in any cycle.
- Out-of-range sel (sel >= OUTPUT_COUNT, possible when OUTPUT_COUNT is not a power of 2): the word is silently dropped. No out_valid bit asserts and no lane data changes.
- in_valid = 0: no strobe is produced L cycles later. Data registers hold.
- OUTPUT_COUNT = 1: sel is ignored, L = 1, out <= in when in_valid.
- Reset (rst = 1 at an edge):
  - All valid registers in every level clear to 0, as does out_valid.
  - All data and sel pipeline registers, and out, clear to 0.
  - In-flight words are discarded. A word presented with in_valid on the cycle rst is high is discarded.
  - The first word accepted on the cycle after rst deasserts emerges L cycles later as normal.
- Back-to-back words to the same lane on consecutive cycles produce consecutive strobes with the correct data in each cycle.

Decomposition:
- Shared toolbox header: holds the N-ary tree helpers f_TreeLevels(count, size), f_NodeCount(count, size, level) and f_NodeSpan(count, size, level, node). The same iterator helpers are used by the mux pipeline; extend them rather than duplicating.
- Sub-module demux_pipeline_node: one registered 1-to-DEMUX_SIZE node with parameters WIDTH, SEL_W and CHILDREN (pruned child count). Ports: clk, rst, valid/sel/data in; per-child valid/sel/data out.
- The top level instantiates nodes level by level with generate loops and maps leaf children onto out and out_valid.

Test Plan:
1. WIDTH=4, OUTPUT_COUNT=10, DEMUX_SIZE=2 (L=4). Hold in_valid=1 for 10 cycles with sel=k and in=k for k=0..9 -> out_valid=(1<<k) on cycles 4..13 respectively, out[k]=k; no other strobes.
2. Same configuration, sel=12 and in=7 for one cycle -> no out_valid bit for 6 cycles; all lanes unchanged.
3. DEMUX_SIZE=4, OUTPUT_COUNT=10 (L=2). Send sel=9/in=A, then sel=9/in=B, then sel=0/in=3 on consecutive cycles -> out_valid[9] on cycles 2 and 3 with out[9]=A then B; out_valid[0] on cycle 4 with out[0]=3.
4. OUTPUT_COUNT=10, DEMUX_SIZE=2. Send sel=5/in=F and sel=6/in=E, then assert rst for one cycle two cycles later -> neither strobe appears; all out and out_valid are 0 the cycle after the reset edge. A word sent the cycle after rst deasserts appears 4 cycles later.
5. OUTPUT_COUNT=1. Send in=9 with in_valid=1, then in=3 with in_valid=0 -> out=9 and out_valid=1 one cycle later; the following cycle out stays 9 and out_valid=0.
6. Randomized: 1000 cycles of random valid/sel/in for OUTPUT_COUNT=10 with DEMUX_SIZE in {2,4,8}, checked against a depth-L reference shift model -> zero mismatches, and out_valid never has more than one bit set.
